// File: rtl/fetch_trace_queue_if.sv
// Bus between the instruction-fetch front end and the fetch trace queue.
// The slave modport is the queue's view; the master modport is the view
// of whatever drives the fetch/BTB/pipeline-control side and consumes the head.
interface fetch_trace_queue_if #(
  parameter int DEPTH   = 2,
  parameter int FETCH_N = 4,
  parameter int EXC_W   = 5
);
  // Fetch-side request and group fields
  logic                    inst_req;
  logic                    inst_index_ok;
  logic [FETCH_N-1:0]      pcr_inst_enable_i;
  logic [31:0]             pcr_vaddr_i;
  logic                    pcr_has_exception_i;
  logic [EXC_W-1:0]        pcr_exc_code_i;
  logic [32*FETCH_N-1:0]   btb_pred_dest_p_i;
  logic [FETCH_N-1:0]      btb_inst_enable_i;
  logic [31:0]             btb_fifth_vaddr_i;
  logic [31:0]             btb_valid_dest_i;
  logic                    btb_valid_take_i;
  logic                    pcg_need_delay_slot_i;
  // Pipeline control
  logic                    bsc_need_cancel_w_i;
  logic                    cp0_exc_occur_w_i;
  logic                    sct_allowin_w_i;
  // Queue status
  logic                    fct_allow_index_o;
  logic                    fct_valid_o;
  logic [$clog2(DEPTH):0]  fct_count_o;
  logic                    fct_overflow_o;
  // Head entry
  logic [31:0]             fct_vaddr_o;
  logic                    fct_has_exception_o;
  logic [EXC_W-1:0]        fct_exc_code_o;
  logic [FETCH_N-1:0]      fct_origin_enable_o;
  logic [32*FETCH_N-1:0]   fct_pred_dest_p_o;
  logic [FETCH_N-1:0]      fct_btb_inst_enable_o;
  logic [31:0]             fct_btb_fifth_vaddr_o;
  logic [31:0]             fct_btb_valid_dest_o;
  logic                    fct_btb_valid_take_o;
  logic                    fct_need_delay_slot_o;
  logic                    fct_is_canceled_o;

  modport slave (
    input  inst_req, inst_index_ok, pcr_inst_enable_i, pcr_vaddr_i,
           pcr_has_exception_i, pcr_exc_code_i, btb_pred_dest_p_i,
           btb_inst_enable_i, btb_fifth_vaddr_i, btb_valid_dest_i,
           btb_valid_take_i, pcg_need_delay_slot_i, bsc_need_cancel_w_i,
           cp0_exc_occur_w_i, sct_allowin_w_i,
    output fct_allow_index_o, fct_valid_o, fct_count_o, fct_overflow_o,
           fct_vaddr_o, fct_has_exception_o, fct_exc_code_o,
           fct_origin_enable_o, fct_pred_dest_p_o, fct_btb_inst_enable_o,
           fct_btb_fifth_vaddr_o, fct_btb_valid_dest_o, fct_btb_valid_take_o,
           fct_need_delay_slot_o, fct_is_canceled_o
  );

  modport master (
    output inst_req, inst_index_ok, pcr_inst_enable_i, pcr_vaddr_i,
           pcr_has_exception_i, pcr_exc_code_i, btb_pred_dest_p_i,
           btb_inst_enable_i, btb_fifth_vaddr_i, btb_valid_dest_i,
           btb_valid_take_i, pcg_need_delay_slot_i, bsc_need_cancel_w_i,
           cp0_exc_occur_w_i, sct_allowin_w_i,
    input  fct_allow_index_o, fct_valid_o, fct_count_o, fct_overflow_o,
           fct_vaddr_o, fct_has_exception_o, fct_exc_code_o,
           fct_origin_enable_o, fct_pred_dest_p_o, fct_btb_inst_enable_o,
           fct_btb_fifth_vaddr_o, fct_btb_valid_dest_o, fct_btb_valid_take_o,
           fct_need_delay_slot_o, fct_is_canceled_o
  );
endinterface

// File: rtl/fetch_trace_queue.sv
// Fetch trace queue: remembers, per outstanding cache fetch, the group's
// address, exception status and branch-prediction context until the next
// stage consumes it. Head fields come straight from storage (no input path).
//
// Handshake: an entry is written when inst_req && inst_index_ok (push); the
// head retires when fct_valid_o && sct_allowin_w_i (pop). A push while full
// is only accepted if a pop happens in the same cycle; otherwise it is
// dropped and fct_overflow_o latches until reset. fct_allow_index_o tells
// the cache whether an index accept would be taken this cycle.
module fetch_trace_queue #(
  parameter int DEPTH   = 2,
  parameter int FETCH_N = 4,
  parameter int EXC_W   = 5
) (
  input logic                 clk,
  input logic                 rst,
  fetch_trace_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]           vaddr_q      [DEPTH];
  logic                  has_exc_q    [DEPTH];
  logic [EXC_W-1:0]      exc_code_q   [DEPTH];
  logic [FETCH_N-1:0]    origin_en_q  [DEPTH];
  logic [32*FETCH_N-1:0] pred_dest_q  [DEPTH];
  logic [FETCH_N-1:0]    btb_en_q     [DEPTH];
  logic [31:0]           fifth_q      [DEPTH];
  logic [31:0]           valid_dest_q [DEPTH];
  logic                  take_q       [DEPTH];
  logic                  delay_q      [DEPTH];
  logic                  canceled_q   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;

  logic             push;
  logic             pop;
  logic             cancel;
  logic             full;
  logic             accept;
  logic [DEPTH-1:0] resident;

  // Handshake decode; a full queue still takes a push when the head leaves
  always_comb begin
    push   = bus.inst_req && bus.inst_index_ok;
    pop    = (count != '0) && bus.sct_allowin_w_i;
    cancel = bus.bsc_need_cancel_w_i || bus.cp0_exc_occur_w_i;
    full   = (count == CNT_W'(DEPTH));
    accept = push && (!full || pop);
  end

  // Slot i is occupied when its distance from the read pointer is below count
  always_comb begin
    resident = '0;
    for (int i = 0; i < DEPTH; i++) begin
      resident[i] = (CNT_W'(PTR_W'(i) - rd_ptr) < count);
    end
  end

  // Storage, pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        vaddr_q[i]      <= '0;
        has_exc_q[i]    <= 1'b0;
        exc_code_q[i]   <= '0;
        origin_en_q[i]  <= '0;
        pred_dest_q[i]  <= '0;
        btb_en_q[i]     <= '0;
        fifth_q[i]      <= '0;
        valid_dest_q[i] <= '0;
        take_q[i]       <= 1'b0;
        delay_q[i]      <= 1'b0;
        canceled_q[i]   <= 1'b0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // A cancel poisons everything still waiting; the departing head is spared
      for (int i = 0; i < DEPTH; i++) begin
        if (cancel && resident[i] && !(pop && (PTR_W'(i) == rd_ptr))) begin
          canceled_q[i] <= 1'b1;
        end
      end
      // The write slot is either free or the head leaving this cycle
      if (accept) begin
        vaddr_q[wr_ptr]      <= bus.pcr_vaddr_i;
        has_exc_q[wr_ptr]    <= bus.pcr_has_exception_i;
        exc_code_q[wr_ptr]   <= bus.pcr_exc_code_i;
        origin_en_q[wr_ptr]  <= bus.pcr_inst_enable_i;
        pred_dest_q[wr_ptr]  <= bus.btb_pred_dest_p_i;
        btb_en_q[wr_ptr]     <= bus.btb_inst_enable_i;
        fifth_q[wr_ptr]      <= bus.btb_fifth_vaddr_i;
        valid_dest_q[wr_ptr] <= bus.btb_valid_dest_i;
        take_q[wr_ptr]       <= bus.btb_valid_take_i;
        delay_q[wr_ptr]      <= bus.pcg_need_delay_slot_i;
        canceled_q[wr_ptr]   <= cancel;
        wr_ptr               <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !accept) begin
        count <= count - 1'b1;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign bus.fct_allow_index_o     = (count < CNT_W'(DEPTH)) || pop;
  assign bus.fct_valid_o           = (count != '0);
  assign bus.fct_count_o           = count;
  assign bus.fct_overflow_o        = overflow;
  assign bus.fct_vaddr_o           = vaddr_q[rd_ptr];
  assign bus.fct_has_exception_o   = has_exc_q[rd_ptr];
  assign bus.fct_exc_code_o        = exc_code_q[rd_ptr];
  assign bus.fct_origin_enable_o   = origin_en_q[rd_ptr];
  assign bus.fct_pred_dest_p_o     = pred_dest_q[rd_ptr];
  assign bus.fct_btb_inst_enable_o = btb_en_q[rd_ptr];
  assign bus.fct_btb_fifth_vaddr_o = fifth_q[rd_ptr];
  assign bus.fct_btb_valid_dest_o  = valid_dest_q[rd_ptr];
  assign bus.fct_btb_valid_take_o  = take_q[rd_ptr];
  assign bus.fct_need_delay_slot_o = delay_q[rd_ptr];
  assign bus.fct_is_canceled_o     = canceled_q[rd_ptr];
endmodule

// File: tb/tb_fetch_trace_queue.sv
// Directed bench for fetch_trace_queue: a DEPTH=2 instance for reset, fill,
// full push/pop, overflow and mid-run reset, and a DEPTH=4 instance for
// pointer wrap and cancel marking.
module tb_fetch_trace_queue;
  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];

  fetch_trace_queue_if #(.DEPTH(2), .FETCH_N(4), .EXC_W(5)) bus2 ();
  fetch_trace_queue_if #(.DEPTH(4), .FETCH_N(4), .EXC_W(5)) bus4 ();

  fetch_trace_queue #(.DEPTH(2), .FETCH_N(4), .EXC_W(5)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  fetch_trace_queue #(.DEPTH(4), .FETCH_N(4), .EXC_W(5)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus2.inst_req = 0; bus2.inst_index_ok = 0; bus2.pcr_inst_enable_i = '0;
    bus2.pcr_vaddr_i = '0; bus2.pcr_has_exception_i = 0; bus2.pcr_exc_code_i = '0;
    bus2.btb_pred_dest_p_i = '0; bus2.btb_inst_enable_i = '0; bus2.btb_fifth_vaddr_i = '0;
    bus2.btb_valid_dest_i = '0; bus2.btb_valid_take_i = 0; bus2.pcg_need_delay_slot_i = 0;
    bus2.bsc_need_cancel_w_i = 0; bus2.cp0_exc_occur_w_i = 0; bus2.sct_allowin_w_i = 0;
    bus4.inst_req = 0; bus4.inst_index_ok = 0; bus4.pcr_inst_enable_i = '0;
    bus4.pcr_vaddr_i = '0; bus4.pcr_has_exception_i = 0; bus4.pcr_exc_code_i = '0;
    bus4.btb_pred_dest_p_i = '0; bus4.btb_inst_enable_i = '0; bus4.btb_fifth_vaddr_i = '0;
    bus4.btb_valid_dest_i = '0; bus4.btb_valid_take_i = 0; bus4.pcg_need_delay_slot_i = 0;
    bus4.bsc_need_cancel_w_i = 0; bus4.cp0_exc_occur_w_i = 0; bus4.sct_allowin_w_i = 0;
  endtask

  task automatic push2(input logic [31:0] va);
    bus2.inst_req = 1; bus2.inst_index_ok = 1; bus2.pcr_vaddr_i = va;
  endtask

  task automatic push4(input logic [31:0] va);
    bus4.inst_req = 1; bus4.inst_index_ok = 1; bus4.pcr_vaddr_i = va;
  endtask

  task automatic stop_push();
    bus2.inst_req = 0; bus2.inst_index_ok = 0;
    bus4.inst_req = 0; bus4.inst_index_ok = 0;
  endtask

  initial begin
    rst = 1'b0;
    idle_all();
    #12;
    // Reset state
    check("rst_count", 64'(bus2.fct_count_o), 0);
    check("rst_valid", 64'(bus2.fct_valid_o), 0);
    check("rst_allow", 64'(bus2.fct_allow_index_o), 1);
    check("rst_ovf", 64'(bus2.fct_overflow_o), 0);
    check("rst_vaddr", 64'(bus2.fct_vaddr_o), 0);
    @(negedge clk);
    rst = 1'b1;

    // Fill with a fully populated first entry, visible one cycle after push
    push2(32'hBFC0_0000);
    bus2.pcr_has_exception_i = 1; bus2.pcr_exc_code_i = 5'h0C;
    bus2.pcr_inst_enable_i = 4'b1010; bus2.btb_inst_enable_i = 4'b0110;
    bus2.btb_pred_dest_p_i = {32'h8000_0300, 32'h8000_0200, 32'h8000_0100, 32'h8000_0000};
    bus2.btb_fifth_vaddr_i = 32'hBFC0_0010; bus2.btb_valid_dest_i = 32'h8000_0200;
    bus2.btb_valid_take_i = 1; bus2.pcg_need_delay_slot_i = 1;
    tick();
    check("lat1_valid", 64'(bus2.fct_valid_o), 1);
    check("lat1_count", 64'(bus2.fct_count_o), 1);
    check("lat1_vaddr", 64'(bus2.fct_vaddr_o), 64'h BFC0_0000);
    check("lat1_exc", 64'(bus2.fct_has_exception_o), 1);
    check("lat1_code", 64'(bus2.fct_exc_code_o), 64'h0C);
    check("lat1_orig_en", 64'(bus2.fct_origin_enable_o), 64'hA);
    check("lat1_btb_en", 64'(bus2.fct_btb_inst_enable_o), 64'h6);
    check("lat1_pred0", 64'(bus2.fct_pred_dest_p_o[31:0]), 64'h8000_0000);
    check("lat1_pred3", 64'(bus2.fct_pred_dest_p_o[127:96]), 64'h8000_0300);
    check("lat1_fifth", 64'(bus2.fct_btb_fifth_vaddr_o), 64'hBFC0_0010);
    check("lat1_dest", 64'(bus2.fct_btb_valid_dest_o), 64'h8000_0200);
    check("lat1_take", 64'(bus2.fct_btb_valid_take_o), 1);
    check("lat1_delay", 64'(bus2.fct_need_delay_slot_o), 1);
    check("lat1_cancel", 64'(bus2.fct_is_canceled_o), 0);
    idle_all();
    push2(32'hBFC0_0010);
    tick();
    stop_push();
    check("fill_count", 64'(bus2.fct_count_o), 2);
    check("fill_allow", 64'(bus2.fct_allow_index_o), 0);
    check("fill_head", 64'(bus2.fct_vaddr_o), 64'hBFC0_0000);
    // Request without index accept is not a push
    bus2.inst_req = 1; bus2.pcr_vaddr_i = 32'h9999_9999;
    tick();
    bus2.inst_req = 0;
    check("noidx_count", 64'(bus2.fct_count_o), 2);
    check("noidx_ovf", 64'(bus2.fct_overflow_o), 0);
    // Drain
    bus2.sct_allowin_w_i = 1;
    #1;
    check("full_pop_allow", 64'(bus2.fct_allow_index_o), 1);
    tick();
    check("drain_head1", 64'(bus2.fct_vaddr_o), 64'hBFC0_0010);
    check("drain_exc1", 64'(bus2.fct_has_exception_o), 0);
    check("drain_count1", 64'(bus2.fct_count_o), 1);
    tick();
    check("drain_count0", 64'(bus2.fct_count_o), 0);
    check("drain_valid0", 64'(bus2.fct_valid_o), 0);
    bus2.sct_allowin_w_i = 0;

    // Full with simultaneous push and pop
    push2(32'hBFC0_0000); tick();
    push2(32'hBFC0_0010); tick();
    push2(32'hBFC0_0020); bus2.sct_allowin_w_i = 1; tick();
    stop_push();
    check("pp_count", 64'(bus2.fct_count_o), 2);
    check("pp_head", 64'(bus2.fct_vaddr_o), 64'hBFC0_0010);
    check("pp_ovf", 64'(bus2.fct_overflow_o), 0);
    tick();
    check("pp_head2", 64'(bus2.fct_vaddr_o), 64'hBFC0_0020);
    check("pp_count1", 64'(bus2.fct_count_o), 1);
    tick();
    check("pp_count0", 64'(bus2.fct_count_o), 0);
    bus2.sct_allowin_w_i = 0;

    // Overflow: dropped push, sticky flag
    push2(32'hBFC0_0000); tick();
    push2(32'hBFC0_0010); tick();
    push2(32'hBFC0_0040); tick();
    stop_push();
    check("ovf_flag", 64'(bus2.fct_overflow_o), 1);
    check("ovf_count", 64'(bus2.fct_count_o), 2);
    check("ovf_head", 64'(bus2.fct_vaddr_o), 64'hBFC0_0000);
    tick();
    check("ovf_sticky", 64'(bus2.fct_overflow_o), 1);
    bus2.sct_allowin_w_i = 1;
    tick();
    check("ovf_head2", 64'(bus2.fct_vaddr_o), 64'hBFC0_0010);
    tick();
    check("ovf_drained", 64'(bus2.fct_count_o), 0);
    check("ovf_sticky2", 64'(bus2.fct_overflow_o), 1);
    bus2.sct_allowin_w_i = 0;

    // Asynchronous reset with entries resident
    push2(32'hBFC0_0000); tick();
    push2(32'hBFC0_0010); tick();
    stop_push();
    check("mid_pre_count", 64'(bus2.fct_count_o), 2);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_count", 64'(bus2.fct_count_o), 0);
    check("mid_valid", 64'(bus2.fct_valid_o), 0);
    check("mid_vaddr", 64'(bus2.fct_vaddr_o), 0);
    check("mid_ovf", 64'(bus2.fct_overflow_o), 0);
    check("mid_allow", 64'(bus2.fct_allow_index_o), 1);
    push2(32'hBFC0_0050);
    tick();
    check("rst_ignore_push", 64'(bus2.fct_count_o), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    stop_push();
    check("first_push_count", 64'(bus2.fct_count_o), 1);
    check("first_push_vaddr", 64'(bus2.fct_vaddr_o), 64'hBFC0_0050);
    bus2.sct_allowin_w_i = 1; tick(); bus2.sct_allowin_w_i = 0;
    check("first_push_drain", 64'(bus2.fct_count_o), 0);

    // Wrap on DEPTH=4: two preloaded, then 10 push/pop pairs
    for (int k = 0; k < 2; k++) begin
      push4(32'hA000_0000 + 32'(4 * k));
      exp_q.push_back(32'hA000_0000 + 32'(4 * k));
      tick();
    end
    for (int k = 2; k < 12; k++) begin
      check("wrap_valid", 64'(bus4.fct_valid_o), 1);
      check("wrap_head", 64'(bus4.fct_vaddr_o), 64'(exp_q.pop_front()));
      push4(32'hA000_0000 + 32'(4 * k));
      exp_q.push_back(32'hA000_0000 + 32'(4 * k));
      bus4.sct_allowin_w_i = 1;
      tick();
      check("wrap_count", 64'(bus4.fct_count_o), 2);
    end
    stop_push();
    while (exp_q.size() > 0) begin
      check("wrap_drain", 64'(bus4.fct_vaddr_o), 64'(exp_q.pop_front()));
      tick();
    end
    check("wrap_empty", 64'(bus4.fct_count_o), 0);
    bus4.sct_allowin_w_i = 0;

    // Cancel marks resident entries and the entry pushed with it
    push4(32'hBFC0_0000); tick();
    push4(32'hBFC0_0010); tick();
    push4(32'hBFC0_0030); bus4.cp0_exc_occur_w_i = 1; tick();
    stop_push();
    bus4.cp0_exc_occur_w_i = 0;
    check("cxl_count", 64'(bus4.fct_count_o), 3);
    exp_q.push_back(32'hBFC0_0000);
    exp_q.push_back(32'hBFC0_0010);
    exp_q.push_back(32'hBFC0_0030);
    bus4.sct_allowin_w_i = 1;
    while (exp_q.size() > 0) begin
      check("cxl_head", 64'(bus4.fct_vaddr_o), 64'(exp_q.pop_front()));
      check("cxl_flag", 64'(bus4.fct_is_canceled_o), 1);
      tick();
    end
    bus4.sct_allowin_w_i = 0;
    check("cxl_empty", 64'(bus4.fct_count_o), 0);
    push4(32'hBFC0_0060); tick();
    stop_push();
    check("nocxl_head", 64'(bus4.fct_vaddr_o), 64'hBFC0_0060);
    check("nocxl_flag", 64'(bus4.fct_is_canceled_o), 0);
    bus4.bsc_need_cancel_w_i = 1; tick();
    bus4.bsc_need_cancel_w_i = 0;
    check("bsc_flag", 64'(bus4.fct_is_canceled_o), 1);
    check("bsc_keep", 64'(bus4.fct_count_o), 1);
    bus4.sct_allowin_w_i = 1; tick(); bus4.sct_allowin_w_i = 0;
    check("bsc_drain", 64'(bus4.fct_count_o), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fetch_trace_queue.md
FETCH_TRACE_QUEUE -- requirements
Module: fetch_trace_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2: trace entries held; power of two, 2..8.
REQ-002 SHALL have parameter FETCH_N, default 4: instruction slots per fetch group.
REQ-003 SHALL have parameter EXC_W, default 5: exception-code width.
REQ-004 SHALL have ports (name direction width meaning):
 clk  in  1  single clock, all state on rising edge.
 rst  in  1  asynchronous active-low reset.
 inst_req  in  1  cache fetch request.
 inst_index_ok  in  1  cache accepted index this cycle.
 pcr_inst_enable_i  in  FETCH_N  wanted slots of this group.
 pcr_vaddr_i  in  32  group virtual address.
 pcr_has_exception_i  in  1  group carries exception.
 pcr_exc_code_i  in  EXC_W  exception code.
 btb_pred_dest_p_i  in  32*FETCH_N  per-slot predicted targets.
 btb_inst_enable_i  in  FETCH_N  BTB-wanted slots.
 btb_fifth_vaddr_i  in  32  next-group address.
 btb_valid_dest_i  in  32  final predicted target.
 btb_valid_take_i  in  1  final taken prediction.
 pcg_need_delay_slot_i  in  1  delay slot outstanding.
 bsc_need_cancel_w_i  in  1  branch-check cancel.
 cp0_exc_occur_w_i  in  1  exception flush.
 sct_allowin_w_i  in  1  next stage accepts head.
 fct_allow_index_o  out  1  cache may assert inst_index_ok next accept.
 fct_valid_o  out  1  head entry valid.
 fct_count_o  out  $clog2(DEPTH)+1  occupancy.
 fct_overflow_o  out  1  sticky push-while-full error.
 fct_* outputs  out  per field  head entry: vaddr, has_exception, exc_code, origin_enable, pred_dest_p, btb_inst_enable, btb_fifth_vaddr, btb_valid_dest, btb_valid_take, need_delay_slot, is_canceled.

Function
REQ-005 SHALL define push = inst_req && inst_index_ok; pop = fct_valid_o && sct_allowin_w_i; cancel = bsc_need_cancel_w_i || cp0_exc_occur_w_i.
REQ-006 SHALL store on push, at write pointer, all input fields plus is_canceled = cancel of the same cycle.
REQ-007 SHALL retire head on pop; read pointer advances modulo DEPTH.
REQ-008 SHALL drive fct_* head fields directly from storage at read pointer (registered, zero combinational path from inputs).
REQ-009 SHALL assert fct_valid_o iff count != 0.
REQ-010 SHALL compute fct_allow_index_o = (count < DEPTH) || pop.
REQ-011 SHALL on push and pop in same cycle keep count unchanged, write and read both complete, including when full.
REQ-012 SHALL on push while full without pop discard the push, leave storage unchanged, set fct_overflow_o until reset.
REQ-013 SHALL on pop while empty do nothing (pop cannot occur, valid low).
REQ-014 SHALL on cancel set is_canceled in every resident entry not being popped that cycle; entries are never removed by cancel.
REQ-015 SHALL give push with simultaneous cancel is_canceled = 1.
REQ-016 SHALL wrap both pointers from DEPTH-1 to 0 with no bubble.
REQ-017 SHALL make a pushed entry visible at fct_* one cycle after push when queue was empty (latency 1).
REQ-018 SHALL keep count in 0..DEPTH; one extra bit width avoids full/empty ambiguity.

Reset
REQ-019 SHALL on rst low, asynchronously: count 0, pointers 0, fct_overflow_o 0, fct_valid_o 0, all storage fields 0 (vaddr 0, exc_code 0, enables 0, flags 0).
REQ-020 SHALL ignore push/pop/cancel while rst low; first push accepted on first rising edge with rst high.
REQ-021 SHALL after reset drive fct_allow_index_o = 1.

Verification
REQ-022 Reset mid-operation: 2 entries resident, rst low between edges -> count 0, fct_valid_o 0, fct_vaddr_o 0 immediately, before next edge.
REQ-023 Fill/drain DEPTH=2: push 0xBFC00000, 0xBFC00010, sct_allowin 0 -> count 2, fct_allow_index_o 0; allowin 1 -> head 0xBFC00000 then 0xBFC00010, count 0.
REQ-024 Full plus simultaneous push/pop: count 2, push 0xBFC00020 with allowin 1 -> count stays 2, order 0x..10 then 0x..20, overflow 0.
REQ-025 Overflow: count 2, allowin 0, push -> overflow 1 sticky, contents unchanged, count 2.
REQ-026 Cancel: 2 entries, cp0_exc_occur_w_i pulse 1 cycle with push of 0xBFC00030 -> all three drain with is_canceled 1; later push without cancel -> is_canceled 0.
REQ-027 Wrap: DEPTH=4, 10 push/pop pairs of incrementing vaddr -> output sequence matches input, no bubble, count constant.
